// File: rtl/counter_array_ctrl.sv
// counter_array_ctrl: access controller for a 1W1R saturating-counter SRAM.
// After reset it sweeps INIT_VAL into every entry. It then serves lookups and
// queued saturating updates on the single read port, forwarding the write
// from the previous cycle so that no read returns a stale counter.
module counter_array_ctrl #(
  parameter int IDX_WIDTH = 8,
  parameter int CNT_WIDTH = 3,
  parameter int INIT_VAL  = 3,
  parameter int UPD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 lookup_valid,
  output logic                 lookup_ready,
  input  logic [IDX_WIDTH-1:0] lookup_idx,
  output logic                 resp_valid,
  output logic [CNT_WIDTH-1:0] resp_counter,
  output logic                 resp_taken,
  input  logic                 update_valid,
  output logic                 update_ready,
  input  logic [IDX_WIDTH-1:0] update_idx,
  input  logic                 update_taken,
  output logic                 csb0,
  output logic [IDX_WIDTH-1:0] addr0,
  output logic [CNT_WIDTH-1:0] din0,
  output logic                 csb1,
  output logic [IDX_WIDTH-1:0] addr1,
  input  logic [CNT_WIDTH-1:0] dout1
);

  localparam int PTR_W  = $clog2(UPD_DEPTH);
  localparam int CNT_QW = PTR_W + 1;
  localparam logic [CNT_WIDTH-1:0] INIT_CNT = CNT_WIDTH'(INIT_VAL);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_QW-1:0]    Q_FULL   = CNT_QW'(UPD_DEPTH);
  localparam logic [CNT_QW-1:0]    Q_EMPTY  = {CNT_QW{1'b0}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating +1 / -1 step of a counter.
  function automatic logic [CNT_WIDTH-1:0] sat_step(input logic [CNT_WIDTH-1:0] c,
                                                    input logic inc);
    logic [CNT_WIDTH-1:0] n;
    if (inc) begin
      if (c == CNT_MAX) n = c;
      else              n = c + CNT_WIDTH'(1);
    end else begin
      if (c == CNT_ZERO) n = c;
      else               n = c - CNT_WIDTH'(1);
    end
    return n;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IDX_WIDTH-1:0] sweep_r;
  logic                 ready_r;

  logic [IDX_WIDTH-1:0] q_idx_r [UPD_DEPTH];
  logic                 q_tkn_r [UPD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_QW-1:0]    q_cnt_r;

  logic                 lk_pend_r;
  logic                 upd_pend_r;
  logic                 upd_tkn_r;
  logic [IDX_WIDTH-1:0] rd_idx_r;

  logic                 fwd_valid_r;
  logic [IDX_WIDTH-1:0] fwd_idx_r;
  logic [CNT_WIDTH-1:0] fwd_data_r;
  logic [CNT_WIDTH-1:0] resp_hold_r;

  logic                 run_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 lk_fire_s;
  logic                 upd_issue_s;
  logic                 enq_s;
  logic [CNT_WIDTH-1:0] data_s;
  logic [CNT_WIDTH-1:0] next_cnt_s;

  // State register: reset always returns to the init sweep.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_INIT;
    else     state_r <= state_nxt_s;
  end

  // Next state: leave INIT once the last index has been written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (&sweep_r) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Sweep index and ready flag (ready is high from the first RUN cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_r <= {IDX_WIDTH{1'b0}};
      ready_r <= 1'b0;
    end else begin
      if (state_r == ST_INIT) sweep_r <= sweep_r + IDX_WIDTH'(1);
      else                    sweep_r <= sweep_r;
      ready_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Outputs: read-port arbitration, forwarding, RMW write and response.
  always_comb begin
    run_s       = (state_r == ST_RUN) && !rst;
    full_s      = (q_cnt_r == Q_FULL);
    empty_s     = (q_cnt_r == Q_EMPTY);
    lk_fire_s   = lookup_valid && run_s && !full_s;
    // A full queue steals the port; otherwise updates only fill idle cycles.
    upd_issue_s = run_s && !empty_s && (full_s || !lookup_valid);
    enq_s       = update_valid && run_s && !full_s;

    ready        = ready_r;
    lookup_ready = run_s && !full_s;
    update_ready = run_s && !full_s;

    csb1 = !(lk_fire_s || upd_issue_s);
    if (lk_fire_s)        addr1 = lookup_idx;
    else if (upd_issue_s) addr1 = q_idx_r[rd_ptr_r];
    else                  addr1 = {IDX_WIDTH{1'b0}};

    // The write driven last cycle is not yet visible on dout1.
    if (fwd_valid_r && (fwd_idx_r == rd_idx_r)) data_s = fwd_data_r;
    else                                        data_s = dout1;
    next_cnt_s = sat_step(data_s, upd_tkn_r);

    if (rst) begin
      csb0  = 1'b1;
      addr0 = {IDX_WIDTH{1'b0}};
      din0  = CNT_ZERO;
    end else if (state_r == ST_INIT) begin
      csb0  = 1'b0;
      addr0 = sweep_r;
      din0  = INIT_CNT;
    end else if (upd_pend_r) begin
      csb0  = 1'b0;
      addr0 = rd_idx_r;
      din0  = next_cnt_s;
    end else begin
      csb0  = 1'b1;
      addr0 = {IDX_WIDTH{1'b0}};
      din0  = CNT_ZERO;
    end

    resp_valid = lk_pend_r && !rst;
    if (lk_pend_r) resp_counter = data_s;
    else           resp_counter = resp_hold_r;
    resp_taken = resp_counter[CNT_WIDTH-1];
  end

  // Update queue storage (contents need no reset; pointers guard them).
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_idx_r[wr_ptr_r] <= update_idx;
      q_tkn_r[wr_ptr_r] <= update_taken;
    end else begin
      q_idx_r[wr_ptr_r] <= q_idx_r[wr_ptr_r];
      q_tkn_r[wr_ptr_r] <= q_tkn_r[wr_ptr_r];
    end
  end

  // Update queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      q_cnt_r  <= Q_EMPTY;
    end else begin
      if (enq_s)       wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (upd_issue_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({enq_s, upd_issue_s})
        2'b10:   q_cnt_r <= q_cnt_r + CNT_QW'(1);
        2'b01:   q_cnt_r <= q_cnt_r - CNT_QW'(1);
        default: q_cnt_r <= q_cnt_r;
      endcase
    end
  end

  // Read pipeline: remember what was read last cycle and why.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_pend_r  <= 1'b0;
      upd_pend_r <= 1'b0;
      upd_tkn_r  <= 1'b0;
      rd_idx_r   <= {IDX_WIDTH{1'b0}};
    end else begin
      lk_pend_r  <= lk_fire_s;
      upd_pend_r <= upd_issue_s;
      upd_tkn_r  <= q_tkn_r[rd_ptr_r];
      rd_idx_r   <= addr1;
    end
  end

  // Forward register mirrors the write driven this cycle; response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_r <= 1'b0;
      fwd_idx_r   <= {IDX_WIDTH{1'b0}};
      fwd_data_r  <= CNT_ZERO;
      resp_hold_r <= CNT_ZERO;
    end else begin
      fwd_valid_r <= !csb0;
      fwd_idx_r   <= addr0;
      fwd_data_r  <= din0;
      if (lk_pend_r) resp_hold_r <= data_s;
      else           resp_hold_r <= resp_hold_r;
    end
  end

endmodule
